// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one register-interface slave among NumReq masters.
// One transaction in flight at a time; a watchdog error-completes hung transfers.

package core_v_mcu_pkg;
  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic        error;
    logic [31:0] rdata;
  } reg_rsp_t;
endpackage

// Per-requester response steering: owner sees the slave (or forced error), others see zero.
module reg_rr_arbiter_rsp_lane #(
  parameter type reg_rsp_t = core_v_mcu_pkg::reg_rsp_t
) (
  input  logic     owner_sel,
  input  logic     fire,
  input  reg_rsp_t slv_rsp,
  output reg_rsp_t lane_rsp
);
  always_comb begin
    lane_rsp = '0;
    if (owner_sel) begin
      if (fire) begin
        lane_rsp.ready = 1'b1;
        lane_rsp.error = 1'b1;
      end else begin
        lane_rsp = slv_rsp;
      end
    end
  end
endmodule

module reg_rr_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter int unsigned TimeoutCycles = 255,
  parameter type         reg_req_t     = core_v_mcu_pkg::reg_req_t,
  parameter type         reg_rsp_t     = core_v_mcu_pkg::reg_rsp_t
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  reg_req_t [NumReq-1:0]     req_i,
  output reg_rsp_t [NumReq-1:0]     rsp_o,
  output reg_req_t                  req_o,
  input  reg_rsp_t                  rsp_i,
  output logic                      busy_o,
  output logic [$clog2(NumReq)-1:0] grant_idx_o,
  output logic                      timeout_o
);
  localparam int unsigned      IdxW    = $clog2(NumReq);
  localparam logic [IdxW:0]    NumReqW = (IdxW+1)'(NumReq);
  localparam logic [IdxW-1:0]  LastIdx = IdxW'(NumReq - 1);
  localparam bit               WdEn    = (TimeoutCycles != 0);
  localparam logic [15:0]      TLast   = 16'(TimeoutCycles - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, rr_ptr_q, winner, owner_inc;
  logic [IdxW:0]   cand;
  logic [15:0]     tcnt_q;
  logic            busy, any_valid, owner_valid, complete, expiry, fire, done;

  assign busy        = (state_q == BUSY);
  assign owner_valid = req_i[owner_q].valid;
  assign complete    = busy && owner_valid && rsp_i.ready;
  // expiry is purely state-based so req_o never depends on rsp_i
  assign expiry      = WdEn && busy && (tcnt_q == TLast);
  assign fire        = expiry && !complete;
  assign done        = busy && (complete || fire || !owner_valid);
  assign owner_inc   = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    any_valid = 1'b0;
    winner    = rr_ptr_q;
    cand      = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (!any_valid && req_i[cand[IdxW-1:0]].valid) begin
        any_valid = 1'b1;
        winner    = cand[IdxW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid) state_d = BUSY;
      BUSY:    if (done)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      owner_q  <= '0;
      rr_ptr_q <= '0;
      tcnt_q   <= '0;
    end else if (!busy) begin
      if (any_valid) begin
        owner_q <= winner;
        tcnt_q  <= '0;
      end
    end else if (done) begin
      rr_ptr_q <= owner_inc;
    end else begin
      tcnt_q <= tcnt_q + 16'd1;
    end
  end

  always_comb begin
    req_o = '0;
    if (busy) begin
      req_o = req_i[owner_q];
      if (expiry) req_o.valid = 1'b0;
    end
  end

  assign busy_o      = busy;
  assign grant_idx_o = owner_q;
  assign timeout_o   = fire;

  for (genvar k = 0; k < NumReq; k++) begin : g_lane
    reg_rr_arbiter_rsp_lane #(.reg_rsp_t(reg_rsp_t)) u_lane (
      .owner_sel (busy && (owner_q == IdxW'(k))),
      .fire      (fire),
      .slv_rsp   (rsp_i),
      .lane_rsp  (rsp_o[k])
    );
  end
endmodule

// File: tb/tb_reg_rr_arbiter.sv
// Bench for reg_rr_arbiter: directed table, hand-written corner sequences and
// randomized traffic checked against an arithmetic round-robin model.
module tb_reg_rr_arbiter;
  import core_v_mcu_pkg::*;

  localparam int N = 3;
  localparam int T = 8;

  logic              clk;
  logic              rst;
  reg_req_t [N-1:0]  req;
  reg_rsp_t [N-1:0]  rsp_o;
  reg_req_t          req_o;
  reg_rsp_t          rsp;
  logic              busy_o;
  logic [1:0]        grant_idx_o;
  logic              timeout_o;

  int n_cmp = 0;
  int n_bad = 0;

  reg_rr_arbiter #(.NumReq(N), .TimeoutCycles(T)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .rsp_o(rsp_o), .req_o(req_o),
    .rsp_i(rsp), .busy_o(busy_o), .grant_idx_o(grant_idx_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit m_busy = 0;
  int m_owner = 0, m_ptr = 0, m_cnt = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_check();
    reg_req_t er, gr;
    reg_rsp_t [N-1:0] ersp;
    bit eto, cmp, wd;
    er = '0; ersp = '0; eto = 0; cmp = 0; wd = 0;
    if (m_busy) begin
      er  = req[m_owner];
      cmp = req[m_owner].valid && rsp.ready;
      wd  = (m_cnt == T - 1);
      if (wd) er.valid = 1'b0;
      if (wd && !cmp) begin
        ersp[m_owner].ready = 1'b1;
        ersp[m_owner].error = 1'b1;
        eto = 1;
      end else begin
        ersp[m_owner] = rsp;
      end
    end
    gr = req_o;
    // slave-side valid is unspecified when completion meets the deadline
    if (wd && cmp) gr.valid = er.valid;
    chk("m_busy", 128'(busy_o), 128'(m_busy));
    chk("m_grant", 128'(grant_idx_o), 128'(m_owner));
    chk("m_req_o", 128'(gr), 128'(er));
    chk("m_rsp_o", 128'(rsp_o), 128'(ersp));
    chk("m_timeout", 128'(timeout_o), 128'(eto));
  endtask

  task automatic model_update();
    bit cmp, fire, found;
    if (rst) begin
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
    end else if (!m_busy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (!found && req[idx].valid) begin
          found = 1; m_owner = idx; m_busy = 1; m_cnt = 0;
        end
      end
    end else begin
      cmp  = req[m_owner].valid && rsp.ready;
      fire = (m_cnt == T - 1) && !cmp;
      if (cmp || fire || !req[m_owner].valid) begin
        m_busy = 0;
        m_ptr  = (m_owner + 1) % N;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic apply();
    #1;
    if (chk_en) model_check();
    model_update();
  endtask

  task automatic cyc(input bit r, input bit [2:0] v, input bit rdy, input logic [31:0] rd);
    @(negedge clk);
    rst = r;
    for (int k = 0; k < N; k++) begin
      req[k].valid = v[k];
      req[k].write = (k != 0);
      req[k].addr  = 32'h10 + 32'h100 * k;
      req[k].wdata = 32'hA0 + k;
      req[k].wstrb = 4'hF;
    end
    rsp.ready = rdy;
    rsp.error = 1'b0;
    rsp.rdata = rd;
    apply();
  endtask

  typedef struct {
    bit          rst;
    bit [2:0]    vld;
    bit          rdy;
    logic [31:0] rdata;
    bit          e_busy;
    int          e_grant;
    bit          e_reqv;
    logic [31:0] e_addr;
    bit [2:0]    e_rdy;
  } vec_t;

  vec_t tbl[14];

  initial begin
    reg_req_t ew;
    reg_rsp_t er;
    int pulses;
    bit [2:0] hold;
    int rdy_pct;

    rst = 1; req = '0; rsp = '0;
    cyc(1, 3'b000, 0, 0);
    cyc(1, 3'b000, 0, 0);
    chk_en = 1;

    // single zero-wait read, then full 3-way contention from reset
    tbl[0]  = '{0, 3'b000, 0, 32'h0,        0, 0, 0, 32'h0,   3'b000};
    tbl[1]  = '{0, 3'b001, 1, 32'hDEADBEEF, 0, 0, 0, 32'h0,   3'b000};
    tbl[2]  = '{0, 3'b001, 1, 32'hDEADBEEF, 1, 0, 1, 32'h10,  3'b001};
    tbl[3]  = '{0, 3'b000, 0, 32'h0,        0, 0, 0, 32'h0,   3'b000};
    tbl[4]  = '{1, 3'b111, 1, 32'h0,        0, 0, 0, 32'h0,   3'b000};
    tbl[5]  = '{0, 3'b111, 1, 32'h11,       0, 0, 0, 32'h0,   3'b000};
    tbl[6]  = '{0, 3'b111, 1, 32'h22,       1, 0, 1, 32'h10,  3'b001};
    tbl[7]  = '{0, 3'b111, 1, 32'h33,       0, 0, 0, 32'h0,   3'b000};
    tbl[8]  = '{0, 3'b111, 1, 32'h44,       1, 1, 1, 32'h110, 3'b010};
    tbl[9]  = '{0, 3'b111, 1, 32'h55,       0, 1, 0, 32'h0,   3'b000};
    tbl[10] = '{0, 3'b111, 1, 32'h66,       1, 2, 1, 32'h210, 3'b100};
    tbl[11] = '{0, 3'b111, 1, 32'h77,       0, 2, 0, 32'h0,   3'b000};
    tbl[12] = '{0, 3'b111, 1, 32'h88,       1, 0, 1, 32'h10,  3'b001};
    tbl[13] = '{0, 3'b000, 0, 32'h0,        0, 0, 0, 32'h0,   3'b000};

    for (int i = 0; i < 14; i++) begin
      cyc(tbl[i].rst, tbl[i].vld, tbl[i].rdy, tbl[i].rdata);
      chk("t_busy", 128'(busy_o), 128'(tbl[i].e_busy));
      chk("t_grant", 128'(grant_idx_o), 128'(tbl[i].e_grant));
      chk("t_reqv", 128'(req_o.valid), 128'(tbl[i].e_reqv));
      chk("t_rdy", 128'({rsp_o[2].ready, rsp_o[1].ready, rsp_o[0].ready}), 128'(tbl[i].e_rdy));
      chk("t_timeout", 128'(timeout_o), 128'(0));
      if (tbl[i].e_reqv) chk("t_addr", 128'(req_o.addr), 128'(tbl[i].e_addr));
      if (tbl[i].e_rdy != 0) chk("t_rdata", 128'(rsp_o[tbl[i].e_grant].rdata), 128'(tbl[i].rdata));
    end

    // wait states: five not-ready cycles, completion in the sixth (ptr=1 here)
    ew = '0; ew.valid = 1; ew.write = 1; ew.addr = 32'h110; ew.wdata = 32'hA1; ew.wstrb = 4'hF;
    cyc(0, 3'b010, 0, 0);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 3'b010, (i == 6), (i == 6) ? 32'h12345678 : 32'h0);
      chk("ws_req", 128'(req_o), 128'(ew));
      chk("ws_ready", 128'(rsp_o[1].ready), 128'(i == 6));
      chk("ws_timeout", 128'(timeout_o), 128'(0));
    end
    cyc(0, 3'b000, 0, 0);
    chk("ws_idle", 128'(busy_o), 128'(0));

    // watchdog: requester 2 never answered, requester 0 next in line
    pulses = 0;
    cyc(0, 3'b101, 0, 32'hBAD);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 3'b101, 0, 32'hBAD);
      if (timeout_o === 1'b1) pulses++;
      chk("wd_grant", 128'(grant_idx_o), 128'(2));
      if (i == 8) begin
        er = '0; er.ready = 1; er.error = 1;
        chk("wd_rsp", 128'(rsp_o[2]), 128'(er));
        chk("wd_reqv", 128'(req_o.valid), 128'(0));
      end else begin
        chk("wd_early_rdy", 128'(rsp_o[2].ready), 128'(0));
        chk("wd_early_reqv", 128'(req_o.valid), 128'(1));
      end
    end
    cyc(0, 3'b101, 0, 0);
    if (timeout_o === 1'b1) pulses++;
    chk("wd_idle", 128'(busy_o), 128'(0));
    chk("wd_pulses", 128'(pulses), 128'(1));
    cyc(0, 3'b101, 1, 32'h55);
    chk("wd_next_grant", 128'(grant_idx_o), 128'(0));
    chk("wd_next_rdy", 128'(rsp_o[0].ready), 128'(1));
    cyc(0, 3'b000, 0, 0);

    // completion lands exactly on the deadline cycle (ptr=1)
    cyc(0, 3'b010, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 3'b010, (i == 8), (i == 8) ? 32'hCAFEF00D : 32'h0);
      if (i == 8) begin
        er = '0; er.ready = 1; er.rdata = 32'hCAFEF00D;
        chk("co_rsp", 128'(rsp_o[1]), 128'(er));
        chk("co_timeout", 128'(timeout_o), 128'(0));
      end
    end
    cyc(0, 3'b000, 0, 0);
    chk("co_idle", 128'(busy_o), 128'(0));

    // reset in the 3rd BUSY cycle (ptr=2) clears everything incl. rr_ptr
    cyc(0, 3'b100, 0, 0);
    cyc(0, 3'b100, 0, 0);
    cyc(0, 3'b100, 0, 0);
    cyc(1, 3'b100, 1, 32'h77);
    cyc(0, 3'b000, 0, 0);
    chk("rs_busy", 128'(busy_o), 128'(0));
    chk("rs_grant", 128'(grant_idx_o), 128'(0));
    chk("rs_req", 128'(req_o), 128'(0));
    chk("rs_rsp", 128'(rsp_o), 128'(0));
    chk("rs_timeout", 128'(timeout_o), 128'(0));
    cyc(0, 3'b111, 0, 0);
    cyc(0, 3'b111, 1, 32'h1);
    chk("rs_regrant", 128'(grant_idx_o), 128'(0));
    cyc(0, 3'b000, 0, 0);

    // randomized traffic against the model
    hold = '0;
    rdy_pct = 50;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) begin
        case ($urandom_range(0, 3))
          0: rdy_pct = 0;
          1: rdy_pct = 12;
          2: rdy_pct = 50;
          default: rdy_pct = 100;
        endcase
      end
      @(negedge clk);
      rst = ($urandom_range(0, 499) == 0);
      for (int k = 0; k < N; k++) begin
        if (hold[k]) begin
          if ($urandom_range(0, 7) == 0) hold[k] = 0;
        end else if ($urandom_range(0, 2) == 0) begin
          hold[k]      = 1;
          req[k].write = 1'($urandom);
          req[k].addr  = $urandom;
          req[k].wdata = $urandom;
          req[k].wstrb = 4'($urandom);
        end
        req[k].valid = hold[k];
      end
      rsp.ready = ($urandom_range(1, 100) <= rdy_pct);
      rsp.error = 1'($urandom);
      rsp.rdata = $urandom;
      apply();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
